// File: rtl/midi_rx_parser.sv
// MIDI receive front end: 2-flop synchroniser, 8N1 UART deserialiser and a
// Note On/Off parser with running status, presenting {note, velocity} plus a one-cycle pulse.
module midi_rx_parser #(
  parameter int          CLK_HZ      = 50_000_000,
  parameter int          BAUD        = 31250,
  parameter bit          CHAN_FILTER = 1'b0,
  parameter logic [3:0]  CHAN        = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        midiRx,
  output logic [15:0] dataMidi,
  output logic        MidiInterrupt,
  output logic        noteOff,
  output logic        frameErr
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 2;
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CPB / 2 - 1);

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAITHI} uart_state_t;
  typedef enum logic [1:0] {P_STAT, P_NOTE, P_VEL} parse_state_t;

  logic rxMeta, rxSync, rxPrev, rxFall;

  uart_state_t uState, uStateN;
  logic [CW-1:0] cnt, cntN;
  logic [2:0]    bitIdx, bitIdxN;
  logic [7:0]    shiftReg, shiftN;
  logic          byteValid, byteValidN, frameErrN;

  parse_state_t pState, pStateN;
  logic         rsValid, rsValidN, rsOff, rsOffN;
  logic [3:0]   rsChan, rsChanN;
  logic [6:0]   noteReg, noteRegN;
  logic [15:0]  dataMidiN;
  logic         noteOffN, intN, chanOk;

  // Synchroniser resets to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= midiRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign rxFall = rxPrev & ~rxSync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uState    <= U_IDLE;
      cnt       <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      uState    <= uStateN;
      cnt       <= cntN;
      bitIdx    <= bitIdxN;
      shiftReg  <= shiftN;
      byteValid <= byteValidN;
      frameErr  <= frameErrN;
    end
  end

  always_comb begin
    uStateN    = uState;
    cntN       = cnt;
    bitIdxN    = bitIdx;
    shiftN     = shiftReg;
    byteValidN = 1'b0;
    frameErrN  = 1'b0;
    unique case (uState)
      U_IDLE: begin
        cntN = '0;
        if (rxFall) uStateN = U_START;
      end
      U_START: begin
        if (cnt == HALF_M1) begin
          cntN    = '0;
          bitIdxN = '0;
          uStateN = rxSync ? U_IDLE : U_DATA;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      U_DATA: begin
        if (cnt == BIT_LAST) begin
          cntN    = '0;
          shiftN  = {rxSync, shiftReg[7:1]};
          bitIdxN = bitIdx + 3'd1;
          if (bitIdx == 3'd7) uStateN = U_STOP;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      U_STOP: begin
        if (cnt == BIT_LAST) begin
          cntN = '0;
          if (rxSync) begin
            byteValidN = 1'b1;
            uStateN    = U_IDLE;
          end else begin
            frameErrN = 1'b1;
            uStateN   = U_WAITHI;
          end
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      U_WAITHI: begin
        cntN = '0;
        if (rxSync) uStateN = U_IDLE;
      end
      default: uStateN = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pState        <= P_STAT;
      rsValid       <= 1'b0;
      rsOff         <= 1'b0;
      rsChan        <= '0;
      noteReg       <= '0;
      dataMidi      <= '0;
      noteOff       <= 1'b0;
      MidiInterrupt <= 1'b0;
    end else begin
      pState        <= pStateN;
      rsValid       <= rsValidN;
      rsOff         <= rsOffN;
      rsChan        <= rsChanN;
      noteReg       <= noteRegN;
      dataMidi      <= dataMidiN;
      noteOff       <= noteOffN;
      MidiInterrupt <= intN;
    end
  end

  assign chanOk = !CHAN_FILTER || (rsChan == CHAN);

  always_comb begin
    pStateN   = pState;
    rsValidN  = rsValid;
    rsOffN    = rsOff;
    rsChanN   = rsChan;
    noteRegN  = noteReg;
    dataMidiN = dataMidi;
    noteOffN  = noteOff;
    intN      = 1'b0;
    if (byteValid) begin
      if (shiftReg >= 8'hF8) begin
        // Realtime bytes may interleave anywhere and leave the message untouched.
        pStateN = pState;
      end else if (shiftReg[7]) begin
        if (shiftReg[7:5] == 3'b100) begin
          rsValidN = 1'b1;
          rsOffN   = ~shiftReg[4];
          rsChanN  = shiftReg[3:0];
          pStateN  = P_NOTE;
        end else begin
          rsValidN = 1'b0;
          pStateN  = P_STAT;
        end
      end else begin
        unique case (pState)
          P_STAT: begin
            if (rsValid) begin
              noteRegN = shiftReg[6:0];
              pStateN  = P_VEL;
            end
          end
          P_NOTE: begin
            noteRegN = shiftReg[6:0];
            pStateN  = P_VEL;
          end
          P_VEL: begin
            pStateN = P_STAT;
            if (chanOk) begin
              dataMidiN = {1'b0, noteReg, 1'b0, shiftReg[6:0]};
              noteOffN  = rsOff | (shiftReg[6:0] == 7'd0);
              intN      = 1'b1;
            end
          end
          default: pStateN = P_STAT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: two instances (all channels / channel 0 only) share one serial line;
// a message-level model fills expected queues that a negedge monitor drains.
module tb_midi_rx_parser;

  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31250;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic midiRx = 1'b1;

  logic [15:0] dataAll, dataFlt;
  logic        intAll, intFlt, offAll, offFlt, ferrAll, ferrFlt;

  int compared = 0;
  int mismatched = 0;

  logic [16:0] expAll[$];
  logic [16:0] expFlt[$];
  int expFrm = 0;
  int frmAll = 0;
  int frmFlt = 0;
  logic prevAll = 1'b0;
  logic prevFlt = 1'b0;

  // model state: running status byte (0 = none) and the first data byte of a pair
  logic [7:0] mRs = 8'h00;
  logic [7:0] mD0 = 8'h00;
  int mCount = 0;

  midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHAN_FILTER(1'b0), .CHAN(4'd0)) dutAll (
    .clk(clk), .rst(rst), .midiRx(midiRx), .dataMidi(dataAll),
    .MidiInterrupt(intAll), .noteOff(offAll), .frameErr(ferrAll));

  midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHAN_FILTER(1'b1), .CHAN(4'd0)) dutFlt (
    .clk(clk), .rst(rst), .midiRx(midiRx), .dataMidi(dataFlt),
    .MidiInterrupt(intFlt), .noteOff(offFlt), .frameErr(ferrFlt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    logic [16:0] e;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      mRs = (b < 8'hA0) ? b : 8'h00;
      mCount = 0;
    end else if (mRs != 8'h00) begin
      if (mCount == 0) begin
        mD0 = b;
        mCount = 1;
      end else begin
        e = {(mRs < 8'h90) || (b == 8'h00), mD0, b};
        expAll.push_back(e);
        if (mRs[3:0] == 4'd0) expFlt.push_back(e);
        mCount = 0;
      end
    end
  endtask

  task automatic driveBit(input logic v);
    midiRx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit stopLow);
    if (stopLow) expFrm++;
    else modelByte(b);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(!stopLow);
    if (stopLow) driveBit(1'b1);
  endtask

  task automatic sendPartial(input logic [7:0] b, input int nBits);
    driveBit(1'b0);
    for (int i = 0; i < nBits; i++) driveBit(b[i]);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_dataAll"}, 32'(dataAll), 32'h0);
    check({tag, "_intAll"}, 32'(intAll), 32'h0);
    check({tag, "_offAll"}, 32'(offAll), 32'h0);
    check({tag, "_ferrAll"}, 32'(ferrAll), 32'h0);
    check({tag, "_dataFlt"}, 32'(dataFlt), 32'h0);
    check({tag, "_intFlt"}, 32'(intFlt), 32'h0);
  endtask

  // Monitor: every interrupt pops one expectation; pulses must be exactly one cycle wide.
  always @(negedge clk) begin
    if (rst) begin
      prevAll = 1'b0;
      prevFlt = 1'b0;
    end else begin
      if (intAll) begin
        check("all_pulse_width", 32'(prevAll), 32'h0);
        if (expAll.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL all_unexpected: got %0h expected no pulse", {offAll, dataAll});
        end else begin
          check("all_note", 32'({offAll, dataAll}), 32'(expAll.pop_front()));
        end
      end
      if (intFlt) begin
        check("flt_pulse_width", 32'(prevFlt), 32'h0);
        if (expFlt.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL flt_unexpected: got %0h expected no pulse", {offFlt, dataFlt});
        end else begin
          check("flt_note", 32'({offFlt, dataFlt}), 32'(expFlt.pop_front()));
        end
      end
      if (ferrAll) frmAll++;
      if (ferrFlt) frmFlt++;
      prevAll = intAll;
      prevFlt = intFlt;
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    bit bad;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    rst = 1'b0;
    driveBit(1'b1);

    // Note On, running status, velocity-zero Note On
    sendByte(8'h90, 0); sendByte(8'h3C, 0); sendByte(8'h64, 0);
    sendByte(8'h3E, 0); sendByte(8'h40, 0);
    sendByte(8'h3C, 0); sendByte(8'h00, 0);
    // realtime byte between note and velocity
    sendByte(8'h90, 0); sendByte(8'h3C, 0); sendByte(8'hF8, 0); sendByte(8'h64, 0);
    // framing error on the note byte, then a clean pair
    sendByte(8'h90, 0); sendByte(8'h3C, 1); sendByte(8'h3C, 0); sendByte(8'h64, 0);
    // channel 1 is filtered by dutFlt; Note Off on channel 0 reaches both
    sendByte(8'h91, 0); sendByte(8'h3C, 0); sendByte(8'h64, 0);
    sendByte(8'h80, 0); sendByte(8'h40, 0); sendByte(8'h10, 0);
    // other status clears running status: following data ignored
    sendByte(8'hB0, 0); sendByte(8'h10, 0); sendByte(8'h20, 0);
    driveBit(1'b1);

    // reset in the middle of the velocity byte
    sendByte(8'h90, 0); sendByte(8'h3C, 0);
    sendPartial(8'h64, 4);
    midiRx = 1'b1;
    rst = 1'b1;
    mRs = 8'h00;
    mCount = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("midreset");
    rst = 1'b0;
    driveBit(1'b1);
    driveBit(1'b1);
    sendByte(8'h90, 0); sendByte(8'h3C, 0); sendByte(8'h64, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      bad = 0;
      if (r < 8) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 24) b = {3'b100, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15))};
      else if (r < 28) b = 8'($urandom_range(8'hA0, 8'hF7));
      else if (r < 32) begin
        b = 8'($urandom);
        bad = 1;
      end else if (r < 38) b = 8'h00;
      else b = 8'($urandom_range(0, 127));
      sendByte(b, bad);
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end

    repeat (4 * CPB) @(posedge clk);
    @(negedge clk);
    check("all_queue_left", 32'(expAll.size()), 32'h0);
    check("flt_queue_left", 32'(expFlt.size()), 32'h0);
    check("all_frame_errs", 32'(frmAll), 32'(expFrm));
    check("flt_frame_errs", 32'(frmFlt), 32'(expFrm));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
